pipeline_fetch_unit: RTL and testbench
======================================

# pipeline_fetch_unit

Instruction-fetch and issue stage that sits directly upstream of `pipeline_datapath`. It owns the program counter and the IF/ID instruction register. It resolves B, B.cond and CBZ in the issue stage using the datapath's `earlyZero` and latched flags. It also inserts the single-cycle load-use bubble that `pipeline_datapath` forwarding cannot cover.

## Interface
Parameters:
- `RESET_PC`, 64'd0: PC value loaded on reset.
- `NOP_INSTR`, 32'hD503201F: encoding issued for bubbles and squashed slots.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `imem_instr` input 32: combinational instruction-memory read data at `pc_if`.
- `earlyZero` input 1: datapath zero-check of the forwarded operand of the instruction currently issued.
- `negative` input 1: latched flag from the datapath.
- `overflow` input 1: latched flag from the datapath.
- `zero` input 1: latched flag from the datapath.
- `carry_out` input 1: latched flag from the datapath.
- `pc_if` output 64: fetch address to instruction memory.
- `instruction` output 32: instruction issued to the datapath and control unit this cycle.
- `instr_valid` output 1: 1 when `instruction` is real work; 0 for a bubble or squashed slot.
- `pc_id` output 64: PC of the instruction held in the IF/ID register.
- `stall` output 1: load-use stall asserted this cycle.

## Operation
- Registered state:
  - `pc_if`
  - IF/ID pair: `instr_q`, `pc_id`, `valid_q`
  - `load_q`, `load_rd_q`: the previous issued slot was a valid LDUR, and its Rd.
- Issue mux: `instruction` = (`stall` | !`valid_q`) ? `NOP_INSTR` : `instr_q`.
- `instr_valid` = `valid_q` & !`stall`.
- Decode of `instr_q`:
  - B: [31:26]=000101, imm26.
  - CBZ: [31:24]=10110100, imm19.
  - B.cond: [31:24]=01010100, imm19, cond [3:0]. Supported conditions are EQ, NE, LT, GE; any other cond is not taken.
  - LDUR: [31:21]=11111000010.
  - STUR: [31:21]=11111000000.
- Branch taken condition:
  - B: always taken.
  - CBZ: taken if `earlyZero`.
  - B.EQ: taken if `zero`. B.NE: taken if !`zero`.
  - B.LT: taken if `negative`^`overflow`. B.GE: taken if its inverse.
  - A branch is only taken when issued valid and not stalled.
- Target: `pc_id` + (sign-extended imm << 2), 64-bit wrap-around arithmetic.
- Load-use stall, asserted combinationally when all of the following hold:
  - `load_q`=1 and `load_rd_q`!=31.
  - `valid_q`=1 and `instr_q` is not B or B.cond.
  - `load_rd_q` equals any of: Rn [9:5]; Rm [20:16]; or Rd [4:0] if `instr_q` is STUR or CBZ.
  - I-type Rm-field matches produce false stalls; this is accepted behaviour.
- Edge update priority:
  - Stall: hold `pc_if`, `instr_q`, `pc_id`, `valid_q`. Clear `load_q`.
  - Taken branch: `pc_if`<=target; `instr_q`<=`NOP_INSTR`; `valid_q`<=0 (fetched instruction squashed). `pc_id`<=`pc_if`.
  - Otherwise: `instr_q`<=`imem_instr`; `pc_id`<=`pc_if`; `valid_q`<=1; `pc_if`<=`pc_if`+4.
  - `load_q`<=issued instruction is valid LDUR; `load_rd_q`<=its [4:0].

## Timing
- Reset values (asynchronous):
  - `pc_if`=`RESET_PC`, `pc_id`=0.
  - `instr_q`=`NOP_INSTR`, `valid_q`=0.
  - `load_q`=0, `load_rd_q`=31.
  - Resulting outputs: `instruction`=`NOP_INSTR`, `instr_valid`=0, `stall`=0.
- Fetch-to-issue latency: 1 cycle. After reset deasserts, the first edge issues imem[`RESET_PC`].
- Taken branch penalty: exactly 1 bubble. There is no delay slot.
- Load-use stall: always exactly 1 cycle, because the bubble clears `load_q`. The stalled instruction reissues the following cycle with forwarding from `nextToLastRes`.
- A branch held during a stall is evaluated on reissue, using the flags and `earlyZero` current at that time.
- Reset mid-stall or mid-branch: all state returns to reset values immediately; no partial PC update.

## Configuration
- `PIPELINE_FETCH_PERF_EN` defined adds outputs `perf_cycles`, `perf_stalls` and `perf_taken`, each 32 bits:
  - Free-running counters that wrap at 2^32 and are reset to 0.
  - `perf_stalls` increments on each `stall` cycle.
  - `perf_taken` increments on each taken branch.
- Undefined: these ports and counters do not exist.

## Structure
- `pipeline_pkg` holds:
  - Opcode/mask constants for B, CBZ, B.cond, LDUR, STUR.
  - The `NOP_INSTR` value.
  - Cond-code constants.
  - A `branch_kind_t` enum: NONE, UNCOND, CBZ, COND.
- One sub-module: `load_use_detect`, taking (`load_q`, `load_rd_q`, `instr_q`, `valid_q`) and producing `stall`.

## Test plan
- Reset, then straight-line code imem[0..3] → `pc_if` 0,4,8,12,16 on successive edges; instructions issued in order; `instr_valid`=1 from the first edge.
- B +3 at PC 8 → next cycle issues `NOP_INSTR` with `instr_valid`=0, `pc_if`=20, then imem[20] issues.
- CBZ X3 with `earlyZero`=1 → taken; repeat with `earlyZero`=0 → falls through with no bubble.
- `LDUR X3,[X1,#0]` then `ADDI X4,X3,#1` → `stall`=1 for one cycle, NOP issued, ADDI reissued with `pc_if` held; `LDUR` then `ADDI X4,X31,#1` → no stall.
- B.LT with `negative`=1, `overflow`=0 → taken; with both 1 → not taken; B.cond with cond=HI → not taken.
- `reset` asserted during a load-use stall → all outputs return to reset values asynchronously; with `PIPELINE_FETCH_PERF_EN`, counters return to 0.

Source files
------------

// File: rtl/pipeline_fetch_unit_pkg.sv
// Shared decode constants and helpers for the fetch/issue stage.
// Combinational only, so it has no latency and no backpressure.
package pipeline_pkg;

  localparam logic [31:0] NOP_ENC  = 32'hD503201F;

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;

  localparam logic [3:0]  COND_EQ  = 4'h0;
  localparam logic [3:0]  COND_NE  = 4'h1;
  localparam logic [3:0]  COND_GE  = 4'hA;
  localparam logic [3:0]  COND_LT  = 4'hB;

  localparam logic [4:0]  XZR      = 5'd31;

  typedef enum logic [1:0] {NONE, UNCOND, CBZ, COND} branch_kind_t;

  function automatic branch_kind_t branch_kind(input logic [31:0] instr);
    if (instr[31:26] == OP_B)          return UNCOND;
    else if (instr[31:24] == OP_CBZ)   return CBZ;
    else if (instr[31:24] == OP_BCOND) return COND;
    else                               return NONE;
  endfunction

  function automatic logic is_ldur(input logic [31:0] instr);
    return instr[31:21] == OP_LDUR;
  endfunction

  function automatic logic is_stur(input logic [31:0] instr);
    return instr[31:21] == OP_STUR;
  endfunction

  // Word offset scaled to bytes: imm26 for B, imm19 for CBZ and B.cond.
  function automatic logic [63:0] branch_offset(input logic [31:0] instr);
    if (instr[31:26] == OP_B) return {{36{instr[25]}}, instr[25:0], 2'b00};
    else                      return {{43{instr[23]}}, instr[23:5], 2'b00};
  endfunction

endpackage

// File: rtl/pipeline_fetch_unit_load_use_detect.sv
// Flags a load-use hazard on the instruction sitting in IF/ID.
// Combinational, zero latency; its output is the stage's only stall source.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic        load_q,
  input  logic [4:0]  load_rd_q,
  input  logic [31:0] instr_q,
  input  logic        valid_q,
  output logic        stall
);

  branch_kind_t kind;
  logic         is_branch;
  logic         reads_rd;
  logic         rd_match;

  assign kind      = branch_kind(instr_q);
  assign is_branch = (kind == UNCOND) || (kind == COND);
  assign reads_rd  = is_stur(instr_q) || (kind == CBZ);

  // The Rm field is compared even for I-type encodings; those false stalls cost one bubble only.
  assign rd_match  = (load_rd_q == instr_q[9:5]) ||
                     (load_rd_q == instr_q[20:16]) ||
                     (reads_rd && (load_rd_q == instr_q[4:0]));

  assign stall = load_q && (load_rd_q != XZR) && valid_q && !is_branch && rd_match;

endmodule

// File: rtl/pipeline_fetch_unit.sv
// PC, IF/ID register, issue-stage branch resolution and load-use bubble; 1-cycle fetch-to-issue.
// Stalls hold fetch for one cycle; PIPELINE_FETCH_PERF_EN adds cycle/stall/taken counters.
module pipeline_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] imem_instr,
  input  logic        earlyZero,
  input  logic        negative,
  input  logic        overflow,
  input  logic        zero,
  input  logic        carry_out,
  output logic [63:0] pc_if,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [63:0] pc_id,
  output logic        stall
`ifdef PIPELINE_FETCH_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_taken
`endif
);

  logic [63:0]  pc_q, pc_d;
  logic [63:0]  pc_id_q, pc_id_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         load_q, load_d;
  logic [4:0]   load_rd_q, load_rd_d;
  branch_kind_t kind;
  logic         cond_true;
  logic         taken;
  logic [63:0]  target;
  logic         unused_carry;

  load_use_detect u_load_use_detect (
    .load_q    (load_q),
    .load_rd_q (load_rd_q),
    .instr_q   (instr_q),
    .valid_q   (valid_q),
    .stall     (stall)
  );

  // None of the supported conditions reads C.
  assign unused_carry = carry_out;

  assign pc_if       = pc_q;
  assign pc_id       = pc_id_q;
  assign instr_valid = valid_q & ~stall;
  assign instruction = instr_valid ? instr_q : NOP_INSTR;

  assign kind   = branch_kind(instr_q);
  assign target = pc_id_q + branch_offset(instr_q);

  always_comb begin
    cond_true = 1'b0;
    case (kind)
      UNCOND: cond_true = 1'b1;
      CBZ:    cond_true = earlyZero;
      COND: begin
        case (instr_q[3:0])
          COND_EQ: cond_true = zero;
          COND_NE: cond_true = ~zero;
          COND_LT: cond_true = negative ^ overflow;
          COND_GE: cond_true = ~(negative ^ overflow);
          default: cond_true = 1'b0;
        endcase
      end
      default: cond_true = 1'b0;
    endcase
  end

  assign taken = instr_valid & cond_true;

  always_comb begin
    pc_d    = pc_q;
    pc_id_d = pc_id_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (stall) begin
      pc_d = pc_q;
    end else if (taken) begin
      pc_d    = target;
      pc_id_d = pc_q;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_q + 64'd4;
      pc_id_d = pc_q;
      instr_d = imem_instr;
      valid_d = 1'b1;
    end
    // A stall issues a bubble, which is what clears the load flag.
    load_d    = instr_valid & is_ldur(instr_q);
    load_rd_d = instr_q[4:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      pc_id_q   <= 64'd0;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      load_q    <= 1'b0;
      load_rd_q <= XZR;
    end else begin
      pc_q      <= pc_d;
      pc_id_q   <= pc_id_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      load_q    <= load_d;
      load_rd_q <= load_rd_d;
    end
  end

`ifdef PIPELINE_FETCH_PERF_EN
  logic [31:0] perf_cycles_q, perf_stalls_q, perf_taken_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles_q <= 32'd0;
      perf_stalls_q <= 32'd0;
      perf_taken_q  <= 32'd0;
    end else begin
      perf_cycles_q <= perf_cycles_q + 32'd1;
      perf_stalls_q <= perf_stalls_q + {31'd0, stall};
      perf_taken_q  <= perf_taken_q + {31'd0, taken};
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
  assign perf_taken  = perf_taken_q;
`endif

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Bench for pipeline_fetch_unit: directed program checks plus randomized programs and flags
// compared each cycle against a slot-level model of fetch, issue, branch and load-use rules.
module tb_pipeline_fetch_unit;

  localparam logic [31:0] NOP    = 32'hD503201F;
  localparam logic [31:0] FILLER = 32'h91000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_instr;
  logic        ez = 1'b0, fn = 1'b0, fv = 1'b0, fz = 1'b0, fc = 1'b0;
  logic [63:0] pc_if, pc_id;
  logic [31:0] instruction;
  logic        instr_valid, stall;
`ifdef PIPELINE_FETCH_PERF_EN
  logic [31:0] perf_cycles, perf_stalls, perf_taken;
`endif

  logic [31:0] mem [64];
  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model: next fetch address, the held slot (address, word, real work?) and the last issued load.
  logic [63:0] m_fetch, m_addr;
  logic [31:0] m_word;
  bit          m_real, m_ld;
  logic [4:0]  m_ldrd;
  logic [31:0] m_cyc, m_stl, m_tkn;

  pipeline_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_instr(imem_instr), .earlyZero(ez),
    .negative(fn), .overflow(fv), .zero(fz), .carry_out(fc),
    .pc_if(pc_if), .instruction(instruction), .instr_valid(instr_valid),
    .pc_id(pc_id), .stall(stall)
`ifdef PIPELINE_FETCH_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls), .perf_taken(perf_taken)
`endif
  );

  always #5 clk = ~clk;
  assign imem_instr = mem[pc_if[7:2]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] imem(input logic [63:0] a);
    return mem[a[7:2]];
  endfunction

  function automatic bit m_stall();
    bit is_b, is_bc, reads_rd;
    is_b     = (m_word[31:26] == 6'b000101);
    is_bc    = (m_word[31:24] == 8'h54);
    reads_rd = (m_word[31:21] == 11'h7C0) || (m_word[31:24] == 8'hB4);
    if (!m_ld || m_ldrd == 5'd31 || !m_real || is_b || is_bc) return 1'b0;
    return (m_ldrd == m_word[9:5]) || (m_ldrd == m_word[20:16]) ||
           (reads_rd && m_ldrd == m_word[4:0]);
  endfunction

  function automatic bit m_issuing();
    return m_real && !m_stall();
  endfunction

  function automatic logic [31:0] m_issue();
    return m_issuing() ? m_word : NOP;
  endfunction

  function automatic bit m_taken();
    if (!m_issuing()) return 1'b0;
    if (m_word[31:26] == 6'b000101) return 1'b1;
    if (m_word[31:24] == 8'hB4) return ez;
    if (m_word[31:24] == 8'h54) begin
      case (m_word[3:0])
        4'd0:    return fz;
        4'd1:    return !fz;
        4'd11:   return fn != fv;
        4'd10:   return fn == fv;
        default: return 1'b0;
      endcase
    end
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_target();
    longint off;
    if (m_word[31:26] == 6'b000101) off = longint'($signed(m_word[25:0]));
    else                            off = longint'($signed(m_word[23:5]));
    return m_addr + 64'(off * 4);
  endfunction

  task automatic model_reset();
    m_fetch = 64'd0; m_addr = 64'd0; m_word = NOP; m_real = 1'b0;
    m_ld = 1'b0; m_ldrd = 5'd31;
    m_cyc = 0; m_stl = 0; m_tkn = 0;
  endtask

  task automatic model_edge();
    bit st, tk, iv;
    logic [31:0] iss;
    logic [63:0] tgt;
    st = m_stall(); tk = m_taken(); iv = m_issuing(); iss = m_issue(); tgt = m_target();
    m_cyc++;
    if (st) m_stl++;
    if (tk) m_tkn++;
    if (!st) begin
      m_addr = m_fetch;
      if (tk) begin m_word = NOP; m_real = 1'b0; m_fetch = tgt; end
      else begin m_word = imem(m_fetch); m_real = 1'b1; m_fetch = m_fetch + 64'd4; end
    end
    m_ld   = iv && (iss[31:21] == 11'h7C2);
    m_ldrd = iss[4:0];
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst pc_if", pc_if, 64'd0);
    chk("rst instruction", {32'd0, instruction}, {32'd0, NOP});
    chk("rst instr_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst stall", {63'd0, stall}, 64'd0);
    cyc();
    reset = 1'b0;
  endtask

  task automatic load_prog(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    for (int i = 0; i < 64; i++) mem[i] = FILLER;
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_if", pc_if, m_fetch);
      chk("instruction", {32'd0, instruction}, {32'd0, m_issue()});
      chk("instr_valid", {63'd0, instr_valid}, {63'd0, m_issuing()});
      chk("pc_id", pc_id, m_addr);
      chk("stall", {63'd0, stall}, {63'd0, m_stall()});
`ifdef PIPELINE_FETCH_PERF_EN
      chk("perf_cycles", {32'd0, perf_cycles}, {32'd0, m_cyc});
      chk("perf_stalls", {32'd0, perf_stalls}, {32'd0, m_stl});
      chk("perf_taken", {32'd0, perf_taken}, {32'd0, m_tkn});
`endif
    end
  end

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 7) == 7) ? 5'd31 : 5'($urandom_range(0, 4));
  endfunction

  function automatic logic [31:0] rnd_instr();
    int off;
    logic [31:0] w;
    off = int'($urandom_range(0, 12)) - 6;
    case ($urandom_range(0, 7))
      0: w = 32'h91000000 | ($urandom_range(0, 4095) << 10) | (rreg() << 5) | rreg();
      1: w = 32'h8B000000 | (rreg() << 16) | (rreg() << 5) | rreg();
      2: w = 32'hF8400000 | (rreg() << 5) | rreg();
      3: w = 32'hF8000000 | (rreg() << 5) | rreg();
      4: w = 32'h14000000 | (off & 32'h03FFFFFF);
      5: w = 32'hB4000000 | ((off & 32'h7FFFF) << 5) | rreg();
      6: w = 32'h54000000 | ((off & 32'h7FFFF) << 5) | $urandom_range(0, 15);
      default: w = $urandom;
    endcase
    return w;
  endfunction

  initial begin
    load_prog(FILLER, FILLER, FILLER, FILLER);
    model_reset();
    chk_en = 1'b1;

    // Straight line into B +3 at PC 8.
    load_prog(32'h91000401, 32'h91000822, 32'h14000003, 32'h91000C63);
    mem[5] = 32'h910014A5;
    do_reset();
    cyc(); chk("sl pc_if e1", pc_if, 64'd4);
           chk("sl instr e1", {32'd0, instruction}, 64'h91000401);
           chk("sl valid e1", {63'd0, instr_valid}, 64'd1);
    cyc(); chk("sl pc_if e2", pc_if, 64'd8);
    cyc(); chk("b pc_if e3", pc_if, 64'd12);
           chk("b instr e3", {32'd0, instruction}, 64'h14000003);
           chk("b pc_id e3", pc_id, 64'd8);
    cyc(); chk("b pc_if e4", pc_if, 64'd20);
           chk("b bubble instr", {32'd0, instruction}, {32'd0, NOP});
           chk("b bubble valid", {63'd0, instr_valid}, 64'd0);
    cyc(); chk("b target instr", {32'd0, instruction}, 64'h910014A5);
           chk("b target pc_id", pc_id, 64'd20);

    // CBZ X3, +3: taken then falls through.
    load_prog(32'hB4000063, FILLER, FILLER, FILLER);
    ez = 1'b1; do_reset(); cyc(); cyc();
    chk("cbz taken pc_if", pc_if, 64'd12);
    chk("cbz taken valid", {63'd0, instr_valid}, 64'd0);
    ez = 1'b0; do_reset(); cyc(); cyc();
    chk("cbz fall pc_if", pc_if, 64'd8);
    chk("cbz fall valid", {63'd0, instr_valid}, 64'd1);

    // B.LT +3 and B.HI +3.
    load_prog(32'h5400006B, FILLER, FILLER, FILLER);
    fn = 1'b1; fv = 1'b0; do_reset(); cyc(); cyc();
    chk("blt taken pc_if", pc_if, 64'd12);
    fv = 1'b1; do_reset(); cyc(); cyc();
    chk("blt not pc_if", pc_if, 64'd8);
    mem[0] = 32'h54000068; fv = 1'b0; do_reset(); cyc(); cyc();
    chk("bhi not pc_if", pc_if, 64'd8);
    fn = 1'b0;

    // LDUR X3 then ADDI X4,X3 stalls once; LDUR X3 then ADDI X4,X31 does not.
    load_prog(32'hF8400023, 32'h91000464, 32'hF8400023, 32'h910007E4);
    do_reset(); cyc(); cyc();
    chk("lu stall", {63'd0, stall}, 64'd1);
    chk("lu bubble", {32'd0, instruction}, {32'd0, NOP});
    chk("lu pc held", pc_if, 64'd8);
    cyc();
    chk("lu reissue stall", {63'd0, stall}, 64'd0);
    chk("lu reissue instr", {32'd0, instruction}, 64'h91000464);
    chk("lu reissue pc", pc_if, 64'd8);
    cyc(); cyc();
    chk("lu xzr no stall", {63'd0, stall}, 64'd0);
    chk("lu xzr instr", {32'd0, instruction}, 64'h910007E4);

    // Reset asserted mid-stall, between edges.
    do_reset(); cyc(); cyc();
    chk("mid stall", {63'd0, stall}, 64'd1);
    #3 reset = 1'b1;
    model_reset();
    #1;
    chk("async pc_if", pc_if, 64'd0);
    chk("async pc_id", pc_id, 64'd0);
    chk("async instr", {32'd0, instruction}, {32'd0, NOP});
    chk("async valid", {63'd0, instr_valid}, 64'd0);
    chk("async stall", {63'd0, stall}, 64'd0);
`ifdef PIPELINE_FETCH_PERF_EN
    chk("async perf_cycles", {32'd0, perf_cycles}, 64'd0);
    chk("async perf_stalls", {32'd0, perf_stalls}, 64'd0);
    chk("async perf_taken", {32'd0, perf_taken}, 64'd0);
`endif
    cyc();
    reset = 1'b0;

    // Randomized programs and flags.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 64; i++) mem[i] = rnd_instr();
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        ez = 1'($urandom); fn = 1'($urandom); fv = 1'($urandom);
        fz = 1'($urandom); fc = 1'($urandom);
        if ($urandom_range(0, 399) == 0) do_reset();
        else cyc();
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
